float8_pack_pipe: RTL

// Converts IEEE-754 binary32 values to the 8-bit float format (1 sign, E exponent, M mantissa bits).
// It is the write-side counterpart of the FP8 unpacker: results from the systolic-array

---
 rtl/float8_pack_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/float8_pack_pipe.sv
// binary32 -> FP8 (1/E/M) packer: two-stage valid/ready pipeline with RNE rounding,
// subnormal generation, overflow saturation and saturating overflow/NaN event counters.
module float8_pack_pipe #(
  parameter int E     = 4,
  parameter int M     = 3,
  parameter int BIAS  = (1 << (E - 1)) - 1,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      f32_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       fp8_out,
  output logic [3:0]       flags_out,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] nan_cnt
);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_t;

  localparam logic signed [9:0] EMIN     = 10'(1 - BIAS);
  localparam logic signed [9:0] EBIAS    = 10'(BIAS);
  localparam logic [9:0]        SH_CAP   = 10'(M + 2);
  localparam logic [9:0]        EXP_ONES = 10'((1 << E) - 1);

  // Overflow code: largest finite value when saturating, otherwise infinity.
  function automatic logic [7:0] ovf_code(input logic sign);
    if (SAT != 0) ovf_code = {sign, E'((1 << E) - 2), {M{1'b1}}};
    else          ovf_code = {sign, {E{1'b1}}, {M{1'b0}}};
  endfunction

  // Round a finite nonzero binary32 magnitude to FP8; returns {flags, code}.
  function automatic logic [11:0] round_pack(input logic sign, input logic signed [9:0] e,
                                             input logic [23:0] sig);
    logic [9:0]     sh;
    logic [23:0]    shifted;
    logic [23:0]    lost_mask;
    logic [M-1:0]   frac;
    logic           guard;
    logic           sticky;
    logic           inc;
    logic           inexact;
    logic [9:0]     exp_f;
    logic [M+9:0]   rounded;
    sh        = '0;
    shifted   = sig;
    lost_mask = '0;
    if (e >= EMIN) begin
      exp_f  = 10'(e + EBIAS);
      frac   = sig[22 -: M];
      guard  = sig[22-M];
      sticky = |sig[21-M:0];
    end else begin
      // Beyond M+2 every significand bit already lands below the guard position.
      sh = 10'(EMIN - e);
      if (sh > SH_CAP) sh = SH_CAP;
      shifted   = sig >> sh;
      lost_mask = (24'd1 << sh) - 24'd1;
      exp_f     = '0;
      frac      = shifted[22 -: M];
      guard     = shifted[22-M];
      sticky    = (|shifted[21-M:0]) | (|(sig & lost_mask));
    end
    inexact = guard | sticky;
    inc     = guard & (sticky | frac[0]);
    // Exponent and fraction added as one field so mantissa carries ripple into the exponent.
    rounded = {exp_f, frac} + {{(M+9){1'b0}}, inc};
    if (rounded[M+9:M] >= EXP_ONES)
      round_pack = {4'b0101, ovf_code(sign)};
    else if (rounded == '0)
      round_pack = {4'b0011, sign, 7'd0};
    else
      round_pack = {3'b000, inexact, sign, rounded[E+M-1:0]};
  endfunction

  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // Stage 0 -> 1: classify and unbias
  cls_t              cls_p0;
  logic signed [9:0] exp_p0;
  logic [23:0]       sig_p0;

  always_comb begin
    cls_p0 = CLS_NORM;
    if (f32_in[30:23] == 8'h00)
      cls_p0 = (f32_in[22:0] == '0) ? CLS_ZERO : CLS_SUB;
    else if (f32_in[30:23] == 8'hFF)
      cls_p0 = (f32_in[22:0] == '0) ? CLS_INF : CLS_NAN;
    exp_p0 = $signed({2'b00, f32_in[30:23]}) - 10'sd127;
    sig_p0 = {1'b1, f32_in[22:0]};
  end

  logic              vld_p1;
  logic              sign_p1;
  cls_t              cls_p1;
  logic signed [9:0] exp_p1;
  logic [23:0]       sig_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      sign_p1 <= f32_in[31];
      cls_p1  <= cls_p0;
      exp_p1  <= exp_p0;
      sig_p1  <= sig_p0;
    end
  end

  // Stage 1 -> 2: round, pack, resolve specials
  logic [11:0] res_p1;

  always_comb begin
    res_p1 = '0;
    unique case (cls_p1)
      CLS_ZERO: res_p1 = {4'b0000, sign_p1, 7'd0};
      CLS_SUB:  res_p1 = {4'b0001, sign_p1, 7'd0};
      CLS_INF:  res_p1 = {4'b0000, sign_p1, {E{1'b1}}, {M{1'b0}}};
      CLS_NAN:  res_p1 = {4'b1000, sign_p1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      default:  res_p1 = round_pack(sign_p1, exp_p1, sig_p1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      fp8_out   <= '0;
      flags_out <= '0;
    end else if (advance) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        fp8_out   <= res_p1[7:0];
        flags_out <= res_p1[11:8];
      end
    end
  end

  logic xfer;
  assign xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      nan_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
      nan_cnt <= '0;
    end else begin
      if (xfer && flags_out[2] && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (xfer && flags_out[3] && (nan_cnt != '1)) nan_cnt <= nan_cnt + CNT_W'(1);
    end
  end

endmodule
